rgmii_rx_dly_cal: RTL and testbench



---
 rtl/rgmii_cal_pkg.sv | 24 ++
 rtl/rgmii_preamble_chk.sv | 66 ++++++
 rtl/rgmii_rx_dly_cal.sv | 214 +++++++++++++++++++++
 tb/tb_rgmii_rx_dly_cal.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/rgmii_cal_pkg.sv
// Shared types and constants for the RGMII receive-delay calibration block.
package rgmii_cal_pkg;

  localparam int TAP_W = 5;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam int         MIN_PREAMBLE  = 6;
  // Wide enough to hold MIN_PREAMBLE; the preamble count saturates there.
  localparam int         PRE_CNT_W     = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SETTLE,
    ST_SYNC,
    ST_EVAL,
    ST_NEXT,
    ST_PICK,
    ST_APPLY,
    ST_DONE
  } cal_state_e;

endpackage

// File: rtl/rgmii_preamble_chk.sv
// Frame-start detector and preamble/SFD checker. While enabled, every rising
// edge of gmii_rx_dv opens a frame that ends in exactly one registered
// frame_good or frame_bad pulse. Frames whose dv edge falls outside the
// enable window are never judged.
module rgmii_preamble_chk
  import rgmii_cal_pkg::*;
(
  input  logic       gmii_rx_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       gmii_rx_dv,
  input  logic [7:0] gmii_rxd,
  output logic       frame_good,
  output logic       frame_bad
);

  logic                 dv_q;
  logic                 in_pre;
  logic [PRE_CNT_W-1:0] pre_cnt;

  // Track dv edges and walk the preamble byte by byte.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of statement order.
  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      dv_q       <= 1'b0;
      in_pre     <= 1'b0;
      pre_cnt    <= '0;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
    end else begin
      dv_q       <= gmii_rx_dv;
      frame_good <= 1'b0;
      frame_bad  <= 1'b0;
      if (!enable) begin
        in_pre  <= 1'b0;
        pre_cnt <= '0;
      end else if (!in_pre) begin
        // The first byte of a frame must already be preamble.
        if (gmii_rx_dv && !dv_q) begin
          if (gmii_rxd == PREAMBLE_BYTE) begin
            in_pre  <= 1'b1;
            pre_cnt <= PRE_CNT_W'(1);
          end else begin
            frame_bad <= 1'b1;
          end
        end
      end else if (!gmii_rx_dv) begin
        // dv dropped before the SFD arrived.
        in_pre    <= 1'b0;
        pre_cnt   <= '0;
        frame_bad <= 1'b1;
      end else if (gmii_rxd == PREAMBLE_BYTE) begin
        if (pre_cnt < PRE_CNT_W'(MIN_PREAMBLE)) pre_cnt <= pre_cnt + 1'b1;
      end else begin
        in_pre  <= 1'b0;
        pre_cnt <= '0;
        if (gmii_rxd == SFD_BYTE && pre_cnt >= PRE_CNT_W'(MIN_PREAMBLE))
          frame_good <= 1'b1;
        else
          frame_bad  <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgmii_rx_dly_cal.sv
// Receive-delay calibration controller: sweeps the shared IDELAYE2 tap over
// 0..TAP_MAX, grades each tap on received preambles, then loads the centre of
// the longest passing window (ties resolved toward the lower window).
module rgmii_rx_dly_cal
  import rgmii_cal_pkg::*;
#(
  parameter int unsigned TAP_MAX        = 31,
  parameter int unsigned DEFAULT_TAP    = 0,
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned FRAMES_PER_TAP = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic             gmii_rx_clk,
  input  logic             rst,
  input  logic             cal_start,
  input  logic             gmii_rx_dv,
  input  logic [7:0]       gmii_rxd,
  output logic             dly_ld,
  output logic [TAP_W-1:0] dly_cntvalue,
  output logic             cal_busy,
  output logic             cal_done,
  output logic             cal_fail,
  output logic [TAP_W-1:0] cal_tap,
  output logic [TAP_W-1:0] win_lo,
  output logic [TAP_W-1:0] win_hi
);

  localparam int SET_W = (SETTLE_CYCLES  > 1) ? $clog2(SETTLE_CYCLES)  : 1;
  localparam int FR_W  = (FRAMES_PER_TAP > 1) ? $clog2(FRAMES_PER_TAP) : 1;
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [TAP_W-1:0] TAP_LAST = TAP_W'(TAP_MAX);
  localparam logic [TAP_W-1:0] DEF_TAP  = TAP_W'(DEFAULT_TAP);

  cal_state_e       state;
  logic [TAP_W-1:0] tap;
  logic [31:0]      pass_vec;
  logic             tap_pass;
  logic [SET_W-1:0] settle_cnt;
  logic [FR_W-1:0]  good_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic [5:0]       scan_idx;
  logic [5:0]       run_len;
  logic [TAP_W-1:0] run_start;
  logic [5:0]       best_len;
  logic [TAP_W-1:0] best_lo;
  logic [TAP_W-1:0] best_hi;
  logic             scan_bit;
  logic [5:0]       span;
  logic             tmo_expired;
  logic             frame_good;
  logic             frame_bad;

  // Frames are only judged while the FSM sits in EVAL.
  rgmii_preamble_chk u_chk (
    .gmii_rx_clk (gmii_rx_clk),
    .rst         (rst),
    .enable      (state == ST_EVAL),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rxd    (gmii_rxd),
    .frame_good  (frame_good),
    .frame_bad   (frame_bad)
  );

  // Position 32 reads as a fail so the last open run is closed by the scan.
  assign scan_bit    = scan_idx[5] ? 1'b0 : pass_vec[scan_idx[4:0]];
  // 6-bit span keeps a full 0..31 window free of wraparound.
  assign span        = {1'b0, best_hi} - {1'b0, best_lo};
  assign tmo_expired = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Calibration sequencer with registered strobes and results.
  always_ff @(posedge gmii_rx_clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      tap          <= '0;
      pass_vec     <= '0;
      tap_pass     <= 1'b0;
      settle_cnt   <= '0;
      good_cnt     <= '0;
      tmo_cnt      <= '0;
      scan_idx     <= '0;
      run_len      <= '0;
      run_start    <= '0;
      best_len     <= '0;
      best_lo      <= '0;
      best_hi      <= '0;
      dly_ld       <= 1'b0;
      dly_cntvalue <= DEF_TAP;
      cal_busy     <= 1'b0;
      cal_done     <= 1'b0;
      cal_fail     <= 1'b0;
      cal_tap      <= DEF_TAP;
      win_lo       <= '0;
      win_hi       <= '0;
    end else begin
      dly_ld   <= 1'b0;
      cal_done <= 1'b0;
      case (state)
        // cal_busy is low only here, so a start request mid-sweep is dropped.
        ST_IDLE: begin
          if (cal_start) begin
            cal_busy     <= 1'b1;
            cal_fail     <= 1'b0;
            pass_vec     <= '0;
            tap          <= '0;
            dly_ld       <= 1'b1;
            dly_cntvalue <= '0;
            tmo_cnt      <= '0;
            settle_cnt   <= '0;
            good_cnt     <= '0;
            state        <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          state   <= ST_SETTLE;
        end
        ST_SETTLE: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          if (settle_cnt == SET_W'(SETTLE_CYCLES - 1)) begin
            settle_cnt <= '0;
            state      <= ST_SYNC;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end
        // Let any frame in flight drain so it is never half-judged.
        ST_SYNC: begin
          if (tmo_expired) begin
            tap_pass <= 1'b0;
            state    <= ST_NEXT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (!gmii_rx_dv) state <= ST_EVAL;
          end
        end
        ST_EVAL: begin
          if (frame_bad || tmo_expired) begin
            tap_pass <= 1'b0;
            state    <= ST_NEXT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
            if (frame_good) begin
              if (good_cnt == FR_W'(FRAMES_PER_TAP - 1)) begin
                tap_pass <= 1'b1;
                state    <= ST_NEXT;
              end else begin
                good_cnt <= good_cnt + 1'b1;
              end
            end
          end
        end
        ST_NEXT: begin
          pass_vec[tap] <= tap_pass;
          if (tap == TAP_LAST) begin
            scan_idx <= '0;
            run_len  <= '0;
            best_len <= '0;
            best_lo  <= '0;
            best_hi  <= '0;
            state    <= ST_PICK;
          end else begin
            tap          <= tap + 1'b1;
            dly_ld       <= 1'b1;
            dly_cntvalue <= tap + 1'b1;
            tmo_cnt      <= '0;
            settle_cnt   <= '0;
            good_cnt     <= '0;
            state        <= ST_LOAD;
          end
        end
        // One bit per cycle; a strictly longer run is needed to replace the best.
        ST_PICK: begin
          if (scan_bit) begin
            if (run_len == '0) run_start <= scan_idx[TAP_W-1:0];
            run_len <= run_len + 1'b1;
          end else begin
            if (run_len > best_len) begin
              best_len <= run_len;
              best_lo  <= run_start;
              best_hi  <= TAP_W'(scan_idx - 6'd1);
            end
            run_len <= '0;
          end
          if (scan_idx[5]) state <= ST_APPLY;
          else             scan_idx <= scan_idx + 1'b1;
        end
        ST_APPLY: begin
          dly_ld <= 1'b1;
          if (best_len == '0) begin
            cal_fail     <= 1'b1;
            cal_tap      <= DEF_TAP;
            dly_cntvalue <= DEF_TAP;
            win_lo       <= '0;
            win_hi       <= '0;
          end else begin
            cal_tap      <= TAP_W'({1'b0, best_lo} + (span >> 1));
            dly_cntvalue <= TAP_W'({1'b0, best_lo} + (span >> 1));
            win_lo       <= best_lo;
            win_hi       <= best_hi;
          end
          state <= ST_DONE;
        end
        ST_DONE: begin
          cal_done <= 1'b1;
          cal_busy <= 1'b0;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rgmii_rx_dly_cal.sv
// Directed bench for rgmii_rx_dly_cal: a bus model sends frames whose quality
// depends on the tap currently loaded, and each sweep result is compared with
// hand-computed windows.
module tb_rgmii_rx_dly_cal;

  localparam int K_GOOD   = 0;
  localparam int K_BAD    = 1;
  localparam int K_SHORT  = 2;
  localparam int K_SILENT = 3;

  logic       gmii_rx_clk = 1'b0;
  logic       rst;
  logic       cal_start;
  logic       gmii_rx_dv;
  logic [7:0] gmii_rxd;
  logic       dly_ld;
  logic [4:0] dly_cntvalue;
  logic       cal_busy;
  logic       cal_done;
  logic       cal_fail;
  logic [4:0] cal_tap;
  logic [4:0] win_lo;
  logic [4:0] win_hi;

  int  n_checks = 0;
  int  n_errors = 0;
  int  ld_cnt   = 0;
  int  done_cnt = 0;
  int  kind [32];
  bit  bus_on   = 1'b0;

  rgmii_rx_dly_cal #(.TIMEOUT_CYCLES(200)) dut (
    .gmii_rx_clk  (gmii_rx_clk),
    .rst          (rst),
    .cal_start    (cal_start),
    .gmii_rx_dv   (gmii_rx_dv),
    .gmii_rxd     (gmii_rxd),
    .dly_ld       (dly_ld),
    .dly_cntvalue (dly_cntvalue),
    .cal_busy     (cal_busy),
    .cal_done     (cal_done),
    .cal_fail     (cal_fail),
    .cal_tap      (cal_tap),
    .win_lo       (win_lo),
    .win_hi       (win_hi)
  );

  always #5 gmii_rx_clk = ~gmii_rx_clk;

  always @(negedge gmii_rx_clk) begin
    if (dly_ld)   ld_cnt++;
    if (cal_done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] frame_byte(input int k, input int i);
    case (k)
      K_GOOD:  return (i < 7) ? 8'h55 : (i == 7) ? 8'hD5 : 8'hA0 + 8'(i);
      K_BAD:   return (i < 3) ? 8'h55 : 8'h5D;
      K_SHORT: return (i < 5) ? 8'h55 : (i == 5) ? 8'hD5 : 8'hA0 + 8'(i);
      default: return 8'h00;
    endcase
  endfunction

  // Bus model: 4 idle cycles then a 12-byte frame whose shape is chosen by the
  // tap loaded at the frame's start.
  initial begin
    int k;
    gmii_rx_dv = 1'b0;
    gmii_rxd   = 8'h00;
    forever begin
      repeat (4) begin
        @(negedge gmii_rx_clk);
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
      end
      k = bus_on ? kind[dly_cntvalue] : K_SILENT;
      for (int i = 0; i < 12; i++) begin
        @(negedge gmii_rx_clk);
        gmii_rx_dv = (k != K_SILENT);
        gmii_rxd   = frame_byte(k, i);
      end
    end
  end

  task automatic start_cal(input string tag);
    @(negedge gmii_rx_clk);
    cal_start = 1'b1;
    @(negedge gmii_rx_clk);
    cal_start = 1'b0;
    check({tag, "_busy_rise"}, cal_busy, 1);
    check({tag, "_first_ld"}, dly_ld, 1);
    check({tag, "_first_tap"}, dly_cntvalue, 0);
    check({tag, "_fail_clr"}, cal_fail, 0);
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int n = 0; n < 20000; n++) begin
      if (cal_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge gmii_rx_clk);
    end
    check({tag, "_done_seen"}, seen, 1);
    check({tag, "_busy_fall"}, cal_busy, 0);
  endtask

  task automatic wait_ld_tap(input string tag, input logic [4:0] t);
    bit seen = 1'b0;
    for (int n = 0; n < 5000; n++) begin
      @(negedge gmii_rx_clk);
      if (dly_ld && dly_cntvalue == t) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_ld_seen"}, seen, 1);
  endtask

  task automatic run_sweep(input string tag, input int exp_lo, input int exp_hi,
                           input int exp_tap, input int exp_fail);
    int ld0, dn0;
    ld0 = ld_cnt;
    dn0 = done_cnt;
    start_cal(tag);
    wait_done(tag);
    repeat (5) @(negedge gmii_rx_clk);
    check({tag, "_win_lo"}, win_lo, exp_lo);
    check({tag, "_win_hi"}, win_hi, exp_hi);
    check({tag, "_cal_tap"}, cal_tap, exp_tap);
    check({tag, "_cntvalue"}, dly_cntvalue, exp_tap);
    check({tag, "_fail"}, cal_fail, exp_fail);
    check({tag, "_ld_pulses"}, ld_cnt - ld0, 33);
    check({tag, "_done_pulses"}, done_cnt - dn0, 1);
  endtask

  initial begin
    int ld0;
    #600000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ld0;
    rst       = 1'b1;
    cal_start = 1'b0;
    repeat (3) @(negedge gmii_rx_clk);
    check("rst_ld", dly_ld, 0);
    check("rst_cntvalue", dly_cntvalue, 0);
    check("rst_busy", cal_busy, 0);
    check("rst_done", cal_done, 0);
    check("rst_fail", cal_fail, 0);
    check("rst_cal_tap", cal_tap, 0);
    check("rst_win", {win_lo, win_hi}, 0);
    rst = 1'b0;

    // Idle after reset: no loads, nothing busy.
    ld0 = ld_cnt;
    repeat (100) @(negedge gmii_rx_clk);
    check("idle_ld_pulses", ld_cnt - ld0, 0);
    check("idle_cal_tap", cal_tap, 0);
    check("idle_busy", cal_busy, 0);

    // Window 10..20 -> centre 15.
    bus_on = 1'b1;
    for (int t = 0; t < 32; t++) kind[t] = (t >= 10 && t <= 20) ? K_GOOD : K_BAD;
    run_sweep("win10_20", 10, 20, 15, 0);

    // Equal-length runs 3..5 and 20..22: the lower one wins.
    for (int t = 0; t < 32; t++)
      kind[t] = ((t >= 3 && t <= 5) || (t >= 20 && t <= 22)) ? K_GOOD : K_BAD;
    run_sweep("tie", 3, 5, 4, 0);

    // Silent bus: every tap times out.
    for (int t = 0; t < 32; t++) kind[t] = K_SILENT;
    run_sweep("silent", 0, 0, 0, 1);

    // Five-byte preamble at tap 7 only: longest run is 8..31.
    for (int t = 0; t < 32; t++) kind[t] = (t == 7) ? K_SHORT : K_GOOD;
    run_sweep("short7", 8, 31, 19, 0);

    // Repeat start mid-sweep is ignored; reset at tap 12 aborts the sweep.
    for (int t = 0; t < 32; t++) kind[t] = K_GOOD;
    start_cal("abort");
    wait_ld_tap("abort_t5", 5'd5);
    cal_start = 1'b1;
    @(negedge gmii_rx_clk);
    cal_start = 1'b0;
    check("abort_busy_kept", cal_busy, 1);
    wait_ld_tap("abort_t6", 5'd6);
    wait_ld_tap("abort_t12", 5'd12);
    rst = 1'b1;
    #1;
    check("abort_rst_busy", cal_busy, 0);
    check("abort_rst_ld", dly_ld, 0);
    check("abort_rst_cntvalue", dly_cntvalue, 0);
    check("abort_rst_cal_tap", cal_tap, 0);
    check("abort_rst_win", {win_lo, win_hi}, 0);
    @(negedge gmii_rx_clk);
    rst = 1'b0;

    // Fresh sweep from tap 0, full 0..31 window.
    run_sweep("full", 0, 31, 15, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
